debug_frame_sender: RTL and testbench

- Parametrised successor to the fixed-layout latch/register dump in the debug state machine.
- Snapshots NUM_CH debug channels (pipeline latches, register/memory words) on request and serialises them byte-wise to the UART transmitter as a framed, checksummed packet.
- Per-channel enable mask, abort and a tx_done watchdog are new.
- Sits between the MIPS debug buses and the uart tx_start/tx_done/data_in handshake, running on the system clock clk.

---
 rtl/debug_frame_sender.sv | 212 +++++++++++++++++++++
 tb/tb_debug_frame_sender.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_frame_sender.sv
// Snapshots NUM_CH debug channels on request and streams them byte-wise to a UART
// as a framed packet: A5, mask, {id, data LSB-first} per enabled channel, XOR checksum.
module debug_frame_sender #(
  parameter int NUM_CH     = 4,
  parameter int CH_BYTES   = 16,
  parameter int TX_TIMEOUT = 65535
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [NUM_CH-1:0]            ch_mask,
  input  logic [NUM_CH*CH_BYTES*8-1:0] ch_data,
  input  logic                         abort,
  input  logic                         tx_done,
  output logic                         tx_start,
  output logic [7:0]                   tx_data,
  output logic                         busy,
  output logic                         done,
  output logic                         error
);

  localparam int CW   = $clog2(NUM_CH) + 1;
  localparam int BW   = $clog2(CH_BYTES) + 1;
  localparam int CSEL = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BSEL = (CH_BYTES > 1) ? $clog2(CH_BYTES) : 1;

  localparam logic [CW-1:0] CH_END    = CW'(NUM_CH);
  localparam logic [BW-1:0] BYTE_LAST = BW'(CH_BYTES - 1);
  localparam logic [31:0]   WD_LAST   = 32'(TX_TIMEOUT - 1);
  localparam bit            WD_ON     = (TX_TIMEOUT != 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_NEXT,
    S_FINISH
  } state_t;

  typedef enum logic [2:0] {
    PH_SOF,
    PH_MASK,
    PH_ID,
    PH_DATA,
    PH_CSUM
  } phase_t;

  state_t                                  state_q;
  phase_t                                  phase_q;
  logic [CW-1:0]                           ch_idx_q;
  logic [BW-1:0]                           byte_idx_q;
  logic [NUM_CH-1:0]                       mask_q;
  logic [NUM_CH-1:0][CH_BYTES-1:0][7:0]    snap_q;
  logic [7:0]                              csum_q;
  logic [31:0]                             wd_cnt_q;
  logic                                    tx_start_q;
  logic [7:0]                              tx_data_q;
  logic                                    busy_q;
  logic                                    done_q;
  logic                                    error_q;

  logic [CW-1:0]   search_from;
  logic [CW-1:0]   nxt_ch;
  logic [7:0]      mask_byte;
  logic [7:0]      cur_byte;
  logic [CSEL-1:0] ch_sel;
  logic [BSEL-1:0] byte_sel;

  assign ch_sel   = ch_idx_q[CSEL-1:0];
  assign byte_sel = byte_idx_q[BSEL-1:0];

  // Lowest enabled channel at or above search_from; CH_END when none is left.
  always_comb begin
    search_from = (phase_q == PH_MASK) ? '0 : ch_idx_q + 1'b1;
    nxt_ch      = CH_END;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (CW'(k) >= search_from && mask_q[k]) begin
        nxt_ch = CW'(k);
      end
    end
  end

  always_comb begin
    mask_byte                = '0;
    mask_byte[NUM_CH-1:0]    = mask_q;
    case (phase_q)
      PH_SOF:  cur_byte = 8'hA5;
      PH_MASK: cur_byte = mask_byte;
      PH_ID:   cur_byte = 8'(ch_idx_q);
      PH_DATA: cur_byte = snap_q[ch_sel][byte_sel];
      default: cur_byte = csum_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      phase_q    <= PH_SOF;
      ch_idx_q   <= '0;
      byte_idx_q <= '0;
      mask_q     <= '0;
      snap_q     <= '0;
      csum_q     <= '0;
      wd_cnt_q   <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else if (abort && state_q != S_IDLE) begin
      state_q    <= S_IDLE;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          tx_start_q <= 1'b0;
          done_q     <= 1'b0;
          if (start) begin
            snap_q     <= ch_data;
            mask_q     <= ch_mask;
            error_q    <= 1'b0;
            csum_q     <= '0;
            phase_q    <= PH_SOF;
            ch_idx_q   <= '0;
            byte_idx_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= S_SEND;
          end
        end

        S_SEND: begin
          tx_start_q <= 1'b1;
          tx_data_q  <= cur_byte;
          wd_cnt_q   <= '0;
          state_q    <= S_WAIT;
        end

        S_WAIT: begin
          tx_start_q <= 1'b0;
          if (tx_done) begin
            state_q <= S_NEXT;
          end else begin
            if (wd_cnt_q != '1) begin
              wd_cnt_q <= wd_cnt_q + 32'd1;
            end
            // wd_cnt_q holds the WAIT cycles before this one
            if (WD_ON && wd_cnt_q >= WD_LAST) begin
              error_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
          end
        end

        S_NEXT: begin
          if (phase_q != PH_SOF && phase_q != PH_CSUM) begin
            csum_q <= csum_q ^ tx_data_q;
          end
          state_q <= S_SEND;
          case (phase_q)
            PH_SOF: phase_q <= PH_MASK;
            PH_MASK: begin
              if (nxt_ch != CH_END) begin
                ch_idx_q <= nxt_ch;
                phase_q  <= PH_ID;
              end else begin
                phase_q <= PH_CSUM;
              end
            end
            PH_ID: begin
              byte_idx_q <= '0;
              phase_q    <= PH_DATA;
            end
            PH_DATA: begin
              if (byte_idx_q == BYTE_LAST) begin
                if (nxt_ch != CH_END) begin
                  ch_idx_q <= nxt_ch;
                  phase_q  <= PH_ID;
                end else begin
                  phase_q <= PH_CSUM;
                end
              end else begin
                byte_idx_q <= byte_idx_q + 1'b1;
              end
            end
            default: begin
              done_q  <= 1'b1;
              state_q <= S_FINISH;
            end
          endcase
        end

        S_FINISH: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_debug_frame_sender.sv
// Directed bench for debug_frame_sender (4 channels x 2 bytes, 20-cycle watchdog)
// with a UART model that returns tx_done 5 cycles after each tx_start.
module tb_debug_frame_sender;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  ch_mask;
  logic [63:0] ch_data;
  logic        abort;
  logic        tx_done = 1'b0;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy;
  logic        done;
  logic        error;

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [7:0]  sent_q[$];
  logic [7:0]  exp_q[$];
  int          n_start = 0;
  int          n_done = 0;
  int          ucnt = 0;
  bit          uart_on;

  debug_frame_sender #(
    .NUM_CH    (4),
    .CH_BYTES  (2),
    .TX_TIMEOUT(20)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .ch_mask (ch_mask),
    .ch_data (ch_data),
    .abort   (abort),
    .tx_done (tx_done),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .busy    (busy),
    .done    (done),
    .error   (error)
  );

  always #5 clk = ~clk;

  // Monitor and UART model share one process so the sampling order is fixed.
  always @(negedge clk) begin
    if (tx_start) begin
      sent_q.push_back(tx_data);
      n_start++;
    end
    if (done) n_done++;
    tx_done = 1'b0;
    if (ucnt > 0) begin
      ucnt--;
      if (ucnt == 0) tx_done = 1'b1;
    end else if (tx_start && uart_on) begin
      ucnt = 5;
    end
  end

  initial begin
    #500000;
    $display("FAIL sim_timeout: observed no end required end");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic start_frame(input logic [3:0] m, input logic [63:0] d);
    ch_mask = m;
    ch_data = d;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  task automatic chk_frame(input string tag, input int sb);
    logic [31:0] got;
    chk_eq({tag, "_len"}, 32'(sent_q.size() - sb), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      got = (sb + i < sent_q.size()) ? {24'h0, sent_q[sb+i]} : 32'hFFFF_FFFF;
      chk_eq($sformatf("%s_b%0d", tag, i), got, {24'h0, exp_q[i]});
    end
  endtask

  // mode 0: plain, 1: start pulsed again while busy, 2: inputs changed after first tx_done
  task automatic run_frame(input string tag, input logic [3:0] m, input logic [63:0] d,
                           input int mode);
    int sb, db, busy_low, lat, n_td, td_t;
    bit seen;
    sb = sent_q.size();
    db = n_done;
    start_frame(m, d);
    chk_eq({tag, "_busy_rise"}, busy, 1);
    chk_eq({tag, "_err_clr"}, error, 0);
    chk_eq({tag, "_txs_send"}, tx_start, 0);
    tick();
    chk_eq({tag, "_first_txs"}, tx_start, 1);
    chk_eq({tag, "_first_sof"}, tx_data, 8'hA5);
    seen = 0; busy_low = 0; lat = -1; n_td = 0; td_t = -100;
    for (int t = 0; t < 800; t++) begin
      if (tx_done) begin
        td_t = t;
        n_td++;
        if (mode == 2 && n_td == 1) begin
          ch_mask = 4'hF;
          ch_data = 64'h0000_0000_0000_5555;
        end
      end
      if (done) begin
        seen = 1;
        lat  = t - td_t;
        break;
      end
      if (!busy) busy_low++;
      start = (mode == 1 && t == 3);
      tick();
    end
    start = 1'b0;
    chk_eq({tag, "_done_seen"}, 32'(seen), 1);
    // final tx_done cycle -> NEXT -> FINISH (done high)
    chk_eq({tag, "_done_lat"}, 32'(lat), 2);
    chk_eq({tag, "_busy_gap"}, 32'(busy_low), 0);
    chk_eq({tag, "_busy_at_done"}, busy, 1);
    chk_eq({tag, "_done_cnt"}, 32'(n_done - db), 1);
    chk_frame(tag, sb);
    tick();
    chk_eq({tag, "_done_pulse"}, done, 0);
    chk_eq({tag, "_busy_fall"}, busy, 0);
  endtask

  initial begin
    int sb, db, w;
    bit hit;
    reset = 1'b0; start = 1'b0; abort = 1'b0; ch_mask = '0; ch_data = '0; uart_on = 1'b1;
    repeat (3) tick();
    chk_eq("rst_tx_start", tx_start, 0);
    chk_eq("rst_tx_data", tx_data, 8'h00);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_done", done, 0);
    chk_eq("rst_error", error, 0);
    reset = 1'b1;
    tick();

    exp_q = '{8'hA5, 8'h05, 8'h00, 8'h34, 8'h12, 8'h02, 8'hEF, 8'hBE, 8'h70};
    run_frame("basic", 4'b0101, 64'h9999_BEEF_7777_1234, 0);

    exp_q = '{8'hA5, 8'h00, 8'h00};
    run_frame("empty", 4'b0000, 64'hFFFF_FFFF_FFFF_FFFF, 1);

    // abort together with the 4th byte's tx_done
    exp_q = '{8'hA5, 8'h05, 8'h00, 8'h34, 8'h12, 8'h02, 8'hEF, 8'hBE, 8'h70};
    sb = n_start;
    db = n_done;
    start_frame(4'b0101, 64'h9999_BEEF_7777_1234);
    hit = 0;
    for (int t = 0; t < 300; t++) begin
      if (n_start - sb >= 4 && tx_done) begin
        hit = 1;
        break;
      end
      tick();
    end
    chk_eq("abort_reach_b4", 32'(hit), 1);
    chk_eq("abort_txs_cnt", 32'(n_start - sb), 4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_eq("abort_busy", busy, 0);
    chk_eq("abort_tx_start", tx_start, 0);
    sb = n_start;
    repeat (30) tick();
    chk_eq("abort_no_tx", 32'(n_start - sb), 0);
    chk_eq("abort_no_done", 32'(n_done - db), 0);
    chk_eq("abort_err", error, 0);

    exp_q = '{8'hA5, 8'h0A, 8'h01, 8'hFF, 8'h00, 8'h03, 8'hA5, 8'hC3, 8'h91};
    run_frame("post_abort", 4'b1010, 64'hC3A5_2222_00FF_1111, 0);

    // watchdog: UART never answers
    uart_on = 1'b0;
    db = n_done;
    start_frame(4'b0001, 64'h0000_0000_0000_1234);
    hit = 0;
    for (int t = 0; t < 10; t++) begin
      if (tx_start) begin
        hit = 1;
        break;
      end
      tick();
    end
    chk_eq("wd_txs", 32'(hit), 1);
    w = 0;
    while (!error && w < 100) begin
      tick();
      w++;
    end
    chk_eq("wd_cycles", 32'(w), 20);
    chk_eq("wd_error", error, 1);
    chk_eq("wd_busy", busy, 0);
    repeat (5) tick();
    chk_eq("wd_no_done", 32'(n_done - db), 0);
    chk_eq("wd_sticky", error, 1);
    uart_on = 1'b1;

    exp_q = '{8'hA5, 8'h01, 8'h00, 8'hAA, 8'hAA, 8'h01};
    run_frame("snap", 4'b0001, 64'h1111_2222_3333_AAAA, 2);

    // reset asserted during SEND of byte 3
    start_frame(4'b0101, 64'h9999_BEEF_7777_1234);
    w = 0;
    for (int t = 0; t < 300; t++) begin
      if (tx_done) begin
        w++;
        if (w == 2) break;
      end
      tick();
    end
    chk_eq("rmf_reach", 32'(w), 2);
    tick();
    tick();
    chk_eq("rmf_pre_data", tx_data, 8'h05);
    chk_eq("rmf_pre_busy", busy, 1);
    reset = 1'b0;
    #2;
    chk_eq("rmf_tx_start", tx_start, 0);
    chk_eq("rmf_busy", busy, 0);
    chk_eq("rmf_tx_data", tx_data, 8'h00);
    tick();
    reset = 1'b1;
    tick();

    exp_q = '{8'hA5, 8'h05, 8'h00, 8'h34, 8'h12, 8'h02, 8'hEF, 8'hBE, 8'h70};
    run_frame("post_rst", 4'b0101, 64'h9999_BEEF_7777_1234, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
